// File: rtl/uart_in_responder.sv
// Simulation-side UART input responder: buffers bench-supplied characters in a
// FIFO and answers the SoC's input poll with the next one, or 0xff when none.
module uart_in_responder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAP   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [7:0]             push_ch,
  input  logic                   uart_in_valid,
  output logic [7:0]             uart_in_ch,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            delivered_cnt,
  output logic [31:0]            idle_poll_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = 8;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]   delivered_q, delivered_d;
  logic [31:0]   idle_poll_q, idle_poll_d;

  logic full, empty, avail;
  logic push_fire, pop_fire, idle_fire;

  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == LW'(0));
    avail     = !empty && (gap_cnt_q == GW'(0));
    push_fire = push_valid && !full;
    pop_fire  = uart_in_valid && avail;
    idle_fire = uart_in_valid && !avail;
  end

  // Next-state for pointers, occupancy, pacing gap and statistics.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    gap_cnt_d   = gap_cnt_q;
    delivered_d = delivered_q;
    idle_poll_d = idle_poll_q;

    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop_fire) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      delivered_d = delivered_q + 32'd1;
      gap_cnt_d   = GW'(GAP);
    end else if (gap_cnt_q != GW'(0)) begin
      gap_cnt_d = gap_cnt_q - GW'(1);
    end

    if (idle_fire) begin
      idle_poll_d = idle_poll_q + 32'd1;
    end

    case ({push_fire, pop_fire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      gap_cnt_q   <= '0;
      delivered_q <= '0;
      idle_poll_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      gap_cnt_q   <= gap_cnt_d;
      delivered_q <= delivered_d;
      idle_poll_q <= idle_poll_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (!reset && push_fire) begin
      mem_q[wr_ptr_q] <= push_ch;
    end
  end

  // Response depends only on registered state so the poller samples it in
  // the same cycle it raises valid.
  always_comb begin
    push_ready    = !full;
    uart_in_ch    = avail ? mem_q[rd_ptr_q] : 8'hff;
    level         = level_q;
    delivered_cnt = delivered_q;
    idle_poll_cnt = idle_poll_q;
  end

endmodule

// File: tb/tb_uart_in_responder.sv
// Bench for uart_in_responder: one instance with GAP=0, one with GAP=3, both
// checked against a queue-based model with delivery pacing tracked in cycles.
module tb_uart_in_responder;

  localparam int unsigned DEPTH = 16;

  logic                  clock = 1'b0;
  logic                  rst   = 1'b0;
  logic [1:0]            pv    = '0;
  logic [1:0][7:0]       pc    = '0;
  logic [1:0]            poll  = '0;
  logic [1:0]            rdy;
  logic [1:0][7:0]       ch;
  logic [1:0][4:0]       lvl;
  logic [1:0][31:0]      dc;
  logic [1:0][31:0]      ic;

  int checks = 0;
  int errors = 0;

  // Model: per-instance queue, earliest cycle a delivery may happen, counters.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  longint      next_ok [2];
  int unsigned dcnt [2];
  int unsigned icnt [2];
  int unsigned gap_p [2];
  longint      cyc_n = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  uart_in_responder #(.DEPTH(DEPTH), .GAP(0)) dut0 (
    .clock(clock), .reset(rst),
    .push_valid(pv[0]), .push_ready(rdy[0]), .push_ch(pc[0]),
    .uart_in_valid(poll[0]), .uart_in_ch(ch[0]), .level(lvl[0]),
    .delivered_cnt(dc[0]), .idle_poll_cnt(ic[0])
  );

  uart_in_responder #(.DEPTH(DEPTH), .GAP(3)) dut1 (
    .clock(clock), .reset(rst),
    .push_valid(pv[1]), .push_ready(rdy[1]), .push_ch(pc[1]),
    .uart_in_valid(poll[1]), .uart_in_ch(ch[1]), .level(lvl[1]),
    .delivered_cnt(dc[1]), .idle_poll_cnt(ic[1])
  );

  function automatic int msize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] mhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // One clock of stimulus on instance k; returns sampled and predicted response.
  task automatic cyc(input int k, input bit r, input bit v, input logic [7:0] c,
                     input bit p, output logic [7:0] got, output logic [7:0] expc);
    longint cur;
    bit av, room;
    @(negedge clock);
    rst  = r;
    pv   = '0;
    pc   = '0;
    poll = '0;
    pv[k]   = v;
    pc[k]   = c;
    poll[k] = p;
    #1;
    got  = ch[k];
    cur  = cyc_n;
    av   = (msize(k) > 0) && (cur >= next_ok[k]);
    room = msize(k) < DEPTH;
    expc = av ? mhead(k) : 8'hff;
    @(posedge clock);
    #1;
    if (r) begin
      q0.delete();
      q1.delete();
      next_ok = '{0, 0};
      dcnt    = '{0, 0};
      icnt    = '{0, 0};
    end else begin
      if (p && av) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        dcnt[k]++;
        next_ok[k] = cur + longint'(gap_p[k]) + 1;
      end else if (p) begin
        icnt[k]++;
      end
      if (v && room) begin
        if (k == 0) q0.push_back(c); else q1.push_back(c);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] g, e;
    for (int i = 0; i < 5; i++) cyc(i % 2, 1'b1, 1'b1, 8'(8'h55 + i), 1'b1, g, e);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got %b exp 1", k, rdy[k]); end
      checks++;
      if (ch[k] !== 8'hff) begin errors++; $display("FAIL reset_ch[%0d] got %h exp ff", k, ch[k]); end
      checks++;
      if (lvl[k] !== 5'd0) begin errors++; $display("FAIL reset_level[%0d] got %0d exp 0", k, lvl[k]); end
      checks++;
      if (dc[k] !== 32'd0 || ic[k] !== 32'd0) begin
        errors++; $display("FAIL reset_cnt[%0d] got %0d/%0d exp 0/0", k, dc[k], ic[k]);
      end
    end
  endtask

  task automatic test_order();
    logic [7:0] g, e;
    logic [7:0] want [4] = '{8'h41, 8'h42, 8'h43, 8'hff};
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 8'(8'h41 + i), 1'b0, g, e);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
      checks++;
      if (g !== want[i] || g !== e) begin
        errors++; $display("FAIL order[%0d] got %h exp %h", i, g, want[i]);
      end
    end
    checks++;
    if (dc[0] !== 32'd3 || ic[0] !== 32'd1 || lvl[0] !== 5'd0) begin
      errors++; $display("FAIL order_cnt got d=%0d i=%0d l=%0d exp 3/1/0", dc[0], ic[0], lvl[0]);
    end
  endtask

  task automatic test_full_wrap();
    logic [7:0] g, e;
    bit v, p;
    for (int i = 0; i < 17; i++) begin
      cyc(0, 1'b0, 1'b1, 8'(i), 1'b0, g, e);
      checks++;
      if (rdy[0] !== (i < 15)) begin
        errors++; $display("FAIL full_ready[%0d] got %b exp %b", i, rdy[0], i < 15);
      end
    end
    checks++;
    if (lvl[0] !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", lvl[0]); end
    cyc(0, 1'b0, 1'b1, 8'h10, 1'b1, g, e);
    checks++;
    if (g !== 8'h00) begin errors++; $display("FAIL full_pop got %h exp 00", g); end
    checks++;
    if (rdy[0] !== 1'b1 || lvl[0] !== 5'd15) begin
      errors++; $display("FAIL full_reopen got r=%b l=%0d exp 1/15", rdy[0], lvl[0]);
    end
    cyc(0, 1'b0, 1'b1, 8'h10, 1'b0, g, e);
    checks++;
    if (lvl[0] !== 5'd16) begin errors++; $display("FAIL full_refill got %0d exp 16", lvl[0]); end
    for (int i = 0; i < 120; i++) begin
      v = (i < 60) ? ($urandom_range(0, 2) != 0) : 1'b0;
      p = $urandom_range(0, 2) != 0;
      cyc(0, 1'b0, v, 8'($urandom), p, g, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_ch[%0d] got %h exp %h", i, g, e); end
    end
    checks++;
    if (lvl[0] !== 5'(q0.size()) || dc[0] !== dcnt[0]) begin
      errors++; $display("FAIL wrap_state got l=%0d d=%0d exp %0d/%0d", lvl[0], dc[0], q0.size(), dcnt[0]);
    end
  endtask

  task automatic test_gap();
    logic [7:0] g, e;
    logic [7:0] want [5] = '{8'h61, 8'hff, 8'hff, 8'hff, 8'h62};
    int unsigned ic0;
    ic0 = ic[1];
    cyc(1, 1'b0, 1'b1, 8'h61, 1'b0, g, e);
    cyc(1, 1'b0, 1'b1, 8'h62, 1'b0, g, e);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
      checks++;
      if (g !== want[i] || g !== e) begin
        errors++; $display("FAIL gap[%0d] got %h exp %h", i, g, want[i]);
      end
    end
    checks++;
    if (ic[1] - ic0 !== 32'd3) begin errors++; $display("FAIL gap_idle got %0d exp 3", ic[1] - ic0); end
  endtask

  task automatic test_simul();
    logic [7:0] g, e;
    for (int i = 0; i < 20; i++) cyc(0, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
    for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b1, 8'(8'hc0 + i), 1'b0, g, e);
    cyc(0, 1'b0, 1'b1, 8'hee, 1'b1, g, e);
    checks++;
    if (g !== 8'hc0 || lvl[0] !== 5'd5) begin
      errors++; $display("FAIL simul_level got ch=%h l=%0d exp c0/5", g, lvl[0]);
    end
    for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
    cyc(0, 1'b0, 1'b1, 8'h7a, 1'b1, g, e);
    checks++;
    if (g !== 8'hff) begin errors++; $display("FAIL simul_nobypass got %h exp ff", g); end
    cyc(0, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
    checks++;
    if (g !== 8'h7a) begin errors++; $display("FAIL simul_next got %h exp 7a", g); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] g, e;
    for (int i = 0; i < 10; i++) cyc(1, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
    for (int i = 0; i < 7; i++) cyc(1, 1'b0, 1'b1, 8'(8'ha0 + i), 1'b0, g, e);
    cyc(1, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
    cyc(1, 1'b0, 1'b0, 8'h00, 1'b0, g, e);
    checks++;
    if (lvl[1] !== 5'd6) begin errors++; $display("FAIL mid_pre got %0d exp 6", lvl[1]); end
    cyc(1, 1'b1, 1'b0, 8'h00, 1'b0, g, e);
    checks++;
    if (lvl[1] !== 5'd0 || ch[1] !== 8'hff) begin
      errors++; $display("FAIL mid_reset got l=%0d ch=%h exp 0/ff", lvl[1], ch[1]);
    end
    cyc(1, 1'b0, 1'b1, 8'h31, 1'b0, g, e);
    cyc(1, 1'b0, 1'b0, 8'h00, 1'b1, g, e);
    checks++;
    if (g !== 8'h31) begin errors++; $display("FAIL mid_after got %h exp 31", g); end
  endtask

  task automatic test_random();
    logic [7:0] g, e;
    int k;
    bit r;
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) == 0);
      cyc(k, r, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1, g, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL rand_ch[%0d] got %h exp %h", i, g, e); end
      checks++;
      if (lvl[k] !== 5'(msize(k)) || rdy[k] !== (msize(k) < DEPTH)) begin
        errors++; $display("FAIL rand_level[%0d] got l=%0d r=%b exp %0d", i, lvl[k], rdy[k], msize(k));
      end
      checks++;
      if (dc[k] !== dcnt[k] || ic[k] !== icnt[k]) begin
        errors++; $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", i, dc[k], ic[k], dcnt[k], icnt[k]);
      end
    end
  endtask

  initial begin
    gap_p   = '{0, 3};
    next_ok = '{0, 0};
    dcnt    = '{0, 0};
    icnt    = '{0, 0};
    test_reset();
    test_order();
    test_full_wrap();
    test_gap();
    test_simul();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
